mult_share_arbiter: RTL

- Shares one sequential shift-and-add unsigned multiplier between two requesters.
- Each requester presents operands m and q with a valid/ready handshake.
- A round-robin arbiter grants one request at a time. The datapath adds (m << i) into an accumulator for each set bit q[i], one bit per cycle.
- The product and the winning requester's id go out on a valid/ready result port. The block sits between the tile's input decode and its output pins and replaces the single-cycle combinational array multiplier where area is tighter than latency.

---
 rtl/mult_share_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mult_share_arbiter.sv
// Two-requester front end sharing one sequential shift-and-add multiplier.
// Round-robin grant in IDLE, W accumulate cycles in CALC, result held in DONE.
module mult_share_arbiter #(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_m,
  input  logic [W-1:0]   req0_q,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_m,
  input  logic [W-1:0]   req1_q,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*W-1:0] res_p,
  output logic           res_id,
  output logic           busy
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic           rr_q, rr_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   m_q, m_d;
  logic [W-1:0]   q_q, q_d;
  logic           id_q, id_d;
  logic [2*W-1:0] res_p_q, res_p_d;
  logic           res_id_q, res_id_d;

  logic           grant0, grant1;
  logic [2*W-1:0] addend;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    m_d        = m_q;
    q_d        = q_q;
    id_d       = id_q;
    res_p_d    = res_p_q;
    res_id_d   = res_id_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    addend     = '0;

    // A lone valid wins outright; on contention rr picks (0 favours requester 0).
    grant0 = req0_valid && (!req1_valid || !rr_q);
    grant1 = req1_valid && (!req0_valid ||  rr_q);

    case (state_q)
      IDLE: begin
        req0_ready = !rst && grant0;
        req1_ready = !rst && grant1;
        if (grant0 || grant1) begin
          m_d     = grant1 ? req1_m : req0_m;
          q_d     = grant1 ? req1_q : req0_q;
          id_d    = grant1;
          rr_d    = !grant1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (q_q[cnt_q]) begin
          addend = {{W{1'b0}}, m_q} << cnt_q;
        end
        acc_d = acc_q + addend;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          res_p_d  = acc_d;
          res_id_d = id_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      m_q      <= '0;
      q_q      <= '0;
      id_q     <= 1'b0;
      res_p_q  <= '0;
      res_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      m_q      <= m_d;
      q_q      <= q_d;
      id_q     <= id_d;
      res_p_q  <= res_p_d;
      res_id_q <= res_id_d;
    end
  end

  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res_p     = res_p_q;
  assign res_id    = res_id_q;

endmodule
